// File: rtl/day10_binary_to_gray_counter.sv
// Up/down binary counter with registered Gray-coded output, parallel load and terminal-count pulse.
// Define DAY10_GRAY_SATURATE_EN to saturate at the bounds instead of wrapping.
module day10_binary_to_gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] gray_reg;
    logic             tc_reg;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             tc_next;
    logic             at_bound;

    // Bound in the commanded direction: all-ones going up, zero going down.
    assign at_bound = up ? (bin_reg == MAX_VAL) : (bin_reg == '0);

    always_comb begin
        bin_next = bin_reg;
        tc_next  = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            tc_next = at_bound;
`ifdef DAY10_GRAY_SATURATE_EN
            if (!at_bound) begin
                bin_next = up ? bin_reg + WIDTH'(1) : bin_reg - WIDTH'(1);
            end
`else
            bin_next = up ? bin_reg + WIDTH'(1) : bin_reg - WIDTH'(1);
`endif
        end
    end

    // Gray is encoded from the next binary value so both registers update on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_next[gi] = bin_next[gi+1] ^ bin_next[gi];
        end
    endgenerate
    assign gray_next[WIDTH-1] = bin_next[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg  <= '0;
            gray_reg <= '0;
            tc_reg   <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            tc_reg   <= tc_next;
        end
    end

    assign bin  = bin_reg;
    assign gray = gray_reg;
    assign tc   = tc_reg;

endmodule

// File: tb/tb_day10_binary_to_gray_counter.sv
// Table-driven check of the Gray counter: each row is one clock of stimulus and the expected registered outputs.
module tb_day10_binary_to_gray_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_bin = 4'd0;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] load_bin;
        logic [3:0] exp_bin;
        logic [3:0] exp_gray;
        logic       exp_tc;
        logic       step;   // counted step that must move gray by exactly one bit
    } vec_t;

    vec_t vecs[$];

    day10_binary_to_gray_counter #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .up(up),
        .load(load),
        .load_bin(load_bin),
        .bin(bin),
        .gray(gray),
        .tc(tc)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic l, input logic e, input logic u,
                                input logic [3:0] lb, input logic [3:0] eb, input logic [3:0] eg,
                                input logic et, input logic st);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.up = u; v.load_bin = lb;
        v.exp_bin = eb; v.exp_gray = eg; v.exp_tc = et; v.step = st;
        vecs.push_back(v);
    endfunction

    task automatic check4(input string name, input int row, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, req);
        end
    endtask

    logic [3:0] up_gray [16];
    logic [3:0] prev_gray;
    logic [3:0] gray_hold;
    logic [3:0] bin_hold;

    initial begin
        up_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                    4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

        // rst, load, en, up, load_bin, exp_bin, exp_gray, exp_tc, step
        add(1, 0, 1, 1, 4'h0, 4'h0, 4'b0000, 0, 0);
`ifdef DAY10_GRAY_SATURATE_EN
        add(0, 1, 0, 0, 4'hE, 4'hE, 4'b1001, 0, 0);
        add(0, 0, 1, 1, 4'h0, 4'hF, 4'b1000, 0, 1);
        add(0, 0, 1, 1, 4'h0, 4'hF, 4'b1000, 1, 0);
        add(0, 0, 1, 1, 4'h0, 4'hF, 4'b1000, 1, 0);
        add(0, 0, 0, 1, 4'h0, 4'hF, 4'b1000, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'h0, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 4'h0, 4'h0, 4'b0000, 1, 0);
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'b0000, 0, 0);
        add(0, 0, 1, 1, 4'h0, 4'h1, 4'b0001, 0, 1);
`else
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 1, 4'h0, 4'(i + 1), up_gray[i], (i == 15), 1);
        add(0, 1, 1, 1, 4'hB, 4'hB, 4'b1110, 0, 0);
        add(0, 0, 1, 1, 4'h0, 4'hC, 4'b1010, 0, 1);
        add(1, 0, 1, 0, 4'h0, 4'h0, 4'b0000, 0, 0);
        add(0, 0, 1, 0, 4'h0, 4'hF, 4'b1000, 1, 1);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 4'h0, 4'hF, 4'b1000, 0, 0);
        add(0, 1, 0, 0, 4'h7, 4'h7, 4'b0100, 0, 0);
        add(1, 0, 1, 1, 4'h0, 4'h0, 4'b0000, 0, 0);
        add(0, 0, 1, 1, 4'h0, 4'h1, 4'b0001, 0, 1);
        add(0, 0, 1, 0, 4'h0, 4'h0, 4'b0000, 0, 1);
        add(0, 0, 1, 0, 4'h0, 4'hF, 4'b1000, 1, 1);
        add(0, 0, 1, 1, 4'h0, 4'h0, 4'b0000, 1, 1);
        add(0, 0, 1, 1, 4'h0, 4'h1, 4'b0001, 0, 1);
`endif

        prev_gray = 4'b0000;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; load = vecs[i].load; en = vecs[i].en;
            up = vecs[i].up; load_bin = vecs[i].load_bin;
            @(posedge clk);
            #1;
            check4("bin", i, bin, vecs[i].exp_bin);
            check4("gray", i, gray, vecs[i].exp_gray);
            check4("tc", i, {3'b000, tc}, {3'b000, vecs[i].exp_tc});
            check4("gray_invariant", i, gray, bin ^ (bin >> 1));
            if (vecs[i].step)
                check4("hamming", i, 4'($countones(gray ^ prev_gray)), 4'd1);
            $display("row %0d: rst=%b load=%b en=%b up=%b load_bin=%b -> bin=%b gray=%b tc=%b",
                     i, vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].load_bin, bin, gray, tc);
            prev_gray = gray;
        end

        // Outputs must not react to inputs between edges.
        bin_hold = vecs[vecs.size() - 1].exp_bin;
        gray_hold = vecs[vecs.size() - 1].exp_gray;
        @(negedge clk);
        load = 1'b1; load_bin = 4'h5; en = 1'b1; up = 1'b0;
        #2;
        check4("no_comb_bin", 0, bin, bin_hold);
        check4("no_comb_gray", 0, gray, gray_hold);
        @(posedge clk);
        #1;
        check4("late_load_bin", 0, bin, 4'h5);
        check4("late_load_gray", 0, gray, 4'b0111);
        $display("comb-path probe: bin=%b gray=%b tc=%b", bin, gray, tc);
        load = 1'b0; en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/day10_binary_to_gray_counter.md
# day10_binary_to_gray_counter

Registered binary-to-Gray encoder built around an up/down binary counter, the encode-side companion to the combinational Gray-to-binary converter. Each enabled cycle it steps a WIDTH-bit binary count and registers both the binary value and its Gray encoding, so the Gray output changes exactly one bit per counted step and never glitches. Used wherever a Gray-coded count must leave its clock domain or drive a position or sequence consumer. A parallel load accepts a binary value and encodes it.

## Interface
- WIDTH, 4, counter and code width in bits; minimum 2.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
- load  input  1  parallel load strobe.
- load_bin  input  WIDTH  binary value loaded when load=1.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin.
- tc  output  1  registered terminal-count flag.

## Operation
- Priority at each rising clk edge: rst > load > en > hold.
- Reset: bin=0, gray=0, tc=0.
- Load: bin<=load_bin; gray<=load_bin ^ (load_bin>>1); tc<=0. Ignores en and up.
- Count with en=1 and up=1: bin<=bin+1, modulo 2^WIDTH.
- Count with en=1 and up=0: bin<=bin-1, modulo 2^WIDTH.
- Gray encoding: gray is always {next_bin[W-1], next_bin[W-1:1]^next_bin[W-2:0]}.
  - It is computed from the next binary value and registered in the same edge as bin.
  - It is never derived combinationally from the bin output.
- Invariant, every cycle: gray == bin ^ (bin>>1).
- Wrap:
  - up from 2^WIDTH-1 to 0 sets tc=1.
  - down from 0 to 2^WIDTH-1 sets tc=1.
  - Every other count step sets tc=0.
- Hold (en=0, load=0): bin and gray keep their values; tc<=0.
- Single-bit property: consecutive counted steps, including wrap, change gray by Hamming distance exactly 1. Load and reset are exempt.

## Timing
- Latency of one clock from a sampled control to the outputs. No combinational path from inputs to outputs.
- tc is a one-cycle pulse aligned with the cycle in which the wrapped value appears on bin and gray.
- rst asserted mid-count clears everything at the next edge. Counting resumes from 0 on the first edge after rst deasserts with en=1.
- A direction change takes effect on the same edge it is sampled. There is no dead cycle.
- Simultaneous load and en: the load value is output unchanged, with no step applied.

## Configuration
- Macro: DAY10_GRAY_SATURATE_EN.
- Undefined (default): modular wrap as described above.
- Defined: the counter saturates instead of wrapping.
  - up at 2^WIDTH-1 holds the value; down at 0 holds the value.
  - tc=1 on every enabled cycle in which the count is held at the bound in the commanded direction.
  - tc=0 when the count moves or when it sits at a bound with en=0.
  - Load, reset and encoding are unchanged.

## Test plan
All scenarios use WIDTH=4.
- Reset: drive rst=1 for one cycle with en=1 -> bin=0000, gray=0000, tc=0.
- Up count: en=1, up=1 from 0 for 16 cycles.
  - gray must follow 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - Each step has Hamming distance 1.
  - tc=1 only with the final 0000.
- Load priority: load=1, load_bin=1011, en=1, up=1 -> next cycle bin=1011, gray=1110, tc=0. The following enabled cycle gives bin=1100, gray=1010.
- Down wrap plus hold:
  - From bin=0 with en=1, up=0 -> bin=1111, gray=1000, tc=1.
  - Then en=0 for 3 cycles -> values held, tc=0.
- Reset mid-count: rst=1 while bin=0111 and en=1 -> next cycle bin=0, gray=0, tc=0. Next enabled up cycle gives gray=0001.
- Saturate build (DAY10_GRAY_SATURATE_EN): load 1110, then en=1, up=1 for 3 cycles.
  - bin sequence 1111, 1111, 1111.
  - gray stays 1000.
  - tc sequence 0, 1, 1.
